// File: rtl/counter_arb_pkg.sv
// Shared types and default parameter values for the counter arbiter slice.
// Imported by counter_arb and rr_pick.
package counter_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_W        = 10;
    localparam int unsigned DEF_N        = 4;
    localparam int unsigned DEF_LOCK_MAX = 8;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first requester after ptr (ptr+1, ptr+2, ... mod N) wins.
// Purely combinational; returns one-hot grant, its index and a valid flag.
module rr_pick
    import counter_arb_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          valid
);

    logic [PW:0] pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = '0;
        // ptr < N and offset <= N, so a single conditional subtract wraps the index
        for (int unsigned k = 1; k <= N; k++) begin
            pos = {1'b0, ptr} + (PW+1)'(k);
            if (pos >= (PW+1)'(N)) begin
                pos = pos - (PW+1)'(N);
            end
            if (!valid && req[pos[PW-1:0]]) begin
                valid = 1'b1;
                idx   = pos[PW-1:0];
            end
        end
        if (valid) begin
            gnt = N'(1) << idx;
        end
    end

endmodule

// File: rtl/counter_arb.sv
// Shared counter arbitrated between N requesters, round-robin with optional
// bounded lock; each transfer clears or increments the counter (wrap at LIMIT).
module counter_arb
    import counter_arb_pkg::*;
#(
    parameter int unsigned W        = DEF_W,
    parameter int unsigned N        = DEF_N,
    parameter int unsigned LIMIT    = 2**(W-1) - 1,
    parameter int unsigned LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] clr,
    input  logic [N-1:0] lock,
    output logic [N-1:0] gnt,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         locked
);

    localparam int unsigned PW = $clog2(N);
    localparam int unsigned CW = $clog2(LOCK_MAX + 1);

    arb_state_e    state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [CW-1:0] lcnt_q, lcnt_d;
    logic [W-1:0]  count_q, count_d;
    logic          wrap_q, wrap_d;

    logic [N-1:0]  pick_gnt;
    logic [PW-1:0] pick_idx;
    logic          pick_valid;
    logic          owner_req;
    logic          xfer;
    logic [PW-1:0] xfer_idx;
    logic [CW-1:0] lcnt_inc;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign owner_req = req[owner_q];

    // Grant path: held at zero through reset so no operation is ever accepted there
    always_comb begin
        gnt      = '0;
        xfer     = 1'b0;
        xfer_idx = owner_q;
        if (rst_n) begin
            if (state_q == ST_LOCKED) begin
                if (owner_req) begin
                    gnt  = N'(1) << owner_q;
                    xfer = 1'b1;
                end
            end else if (pick_valid) begin
                gnt      = pick_gnt;
                xfer     = 1'b1;
                xfer_idx = pick_idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        lcnt_d   = lcnt_q;
        count_d  = count_q;
        wrap_d   = 1'b0;
        lcnt_inc = lcnt_q + CW'(1);

        if (xfer) begin
            if (clr[xfer_idx]) begin
                count_d = '0;
            end else if (count_q == W'(LIMIT)) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end else begin
                count_d = count_q + W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    ptr_d = xfer_idx;
                    if (lock[xfer_idx]) begin
                        if (LOCK_MAX > 1) begin
                            state_d = ST_LOCKED;
                            owner_d = xfer_idx;
                            lcnt_d  = CW'(1);
                        end
                    end
                end
            end
            ST_LOCKED: begin
                // Release parks ptr on the owner so it becomes lowest priority
                if (!owner_req || !lock[owner_q] || lcnt_inc == CW'(LOCK_MAX)) begin
                    state_d = ST_IDLE;
                    ptr_d   = owner_q;
                    lcnt_d  = '0;
                end else begin
                    lcnt_d = lcnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= PW'(N - 1);
            owner_q <= '0;
            lcnt_q  <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            lcnt_q  <= lcnt_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count  = count_q;
    assign wrap   = wrap_q;
    assign locked = (state_q == ST_LOCKED);

    logic started_q;

    always_ff @(posedge clk) begin
        started_q <= 1'b1;
        if (started_q !== 1'b1) begin
            a_init_rst : assume (!rst_n);
        end
        a_rst_gnt : assert (rst_n || gnt == '0);
        if (rst_n) begin
            a_onehot  : assert ($onehot0(gnt));
            a_gnt_req : assert ((gnt & ~req) == '0);
            a_limit   : assert (count_q <= W'(LIMIT));
            a_owner   : assert (!locked || ({1'b0, owner_q} < (PW+1)'(N)));
        end
    end

endmodule
